// File: rtl/score_ssd_driver_if.sv
// Display-side bundle between the block controller and the seven-segment driver.
// master = status producer / pin observer, slave = the driver itself.
interface score_ssd_driver_if;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [3:0] lives;
  logic       game_over;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output score_ones, score_tens, lives, game_over,
    input  an, seg, dp
  );

  modport slave (
    input  score_ones, score_tens, lives, game_over,
    output an, seg, dp
  );
endinterface

// File: rtl/score_ssd_driver.sv
// 4-digit common-anode seven-segment driver: frame-aligned capture of score/lives,
// per-slot anti-ghost guard, leading-zero blanking and life-loss blink.
module score_ssd_driver #(
  parameter int REFRESH_BITS = 18,
  parameter int GUARD        = 16,
  parameter int BLINK_BITS   = 24
) (
  input  logic              clk,
  input  logic              rst,
  score_ssd_driver_if.slave disp
);

  localparam int SLOT_BITS = REFRESH_BITS - 2;
  localparam logic [SLOT_BITS-1:0] GUARD_L = SLOT_BITS'(GUARD);

  logic [REFRESH_BITS-1:0] r_refresh_cnt;
  logic [BLINK_BITS-1:0]   r_blink_cnt;
  logic [2:0]              r_blink_left;
  logic [3:0]              r_sh_ones;
  logic [3:0]              r_sh_tens;
  logic [3:0]              r_sh_lives;
  logic [3:0]              r_an;
  logic [6:0]              r_seg;

  logic [1:0]           w_slot;
  logic [SLOT_BITS-1:0] w_offs;
  logic                 w_capture;
  logic                 w_lives_drop;
  logic                 w_blink_wrap;
  logic [3:0]           w_digit;
  logic [3:0]           w_an_sel;
  logic                 w_blank;
  logic                 w_in_guard;
  logic [3:0]           w_an_next;
  logic [6:0]           w_seg_next;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'd0:    f_decode = 7'b1000000;
      4'd1:    f_decode = 7'b1111001;
      4'd2:    f_decode = 7'b0100100;
      4'd3:    f_decode = 7'b0110000;
      4'd4:    f_decode = 7'b0011001;
      4'd5:    f_decode = 7'b0010010;
      4'd6:    f_decode = 7'b0000010;
      4'd7:    f_decode = 7'b1111000;
      4'd8:    f_decode = 7'b0000000;
      4'd9:    f_decode = 7'b0010000;
      default: f_decode = 7'b0111111;
    endcase
  endfunction

  assign w_slot       = r_refresh_cnt[REFRESH_BITS-1 -: 2];
  assign w_offs       = r_refresh_cnt[SLOT_BITS-1:0];
  assign w_capture    = (&r_refresh_cnt) & ~disp.game_over;
  assign w_lives_drop = w_capture & (disp.lives < r_sh_lives);
  assign w_blink_wrap = &r_blink_cnt;
  assign w_in_guard   = (w_offs < GUARD_L);

  always_comb begin
    w_digit  = 4'd0;
    w_an_sel = 4'b1111;
    w_blank  = 1'b1;
    case (w_slot)
      2'd0: begin
        w_digit  = r_sh_ones;
        w_an_sel = 4'b1110;
        w_blank  = 1'b0;
      end
      2'd1: begin
        w_digit  = r_sh_tens;
        w_an_sel = 4'b1101;
        w_blank  = (r_sh_tens == 4'd0);
      end
      2'd3: begin
        w_digit  = r_sh_lives;
        w_an_sel = 4'b0111;
        w_blank  = r_blink_left[0];
      end
      default: begin
        w_digit  = 4'd0;
        w_an_sel = 4'b1111;
        w_blank  = 1'b1;
      end
    endcase
  end

  // Blank digits and guard time both release the anode, so nothing ghosts.
  assign w_an_next  = (w_in_guard | w_blank) ? '1 : w_an_sel;
  assign w_seg_next = (w_in_guard | w_blank) ? '1 : f_decode(w_digit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_refresh_cnt <= '0;
      r_blink_cnt   <= '0;
      r_blink_left  <= '0;
      r_sh_ones     <= '0;
      r_sh_tens     <= '0;
      r_sh_lives    <= '0;
      r_an          <= '1;
      r_seg         <= '1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
      if (w_capture) begin
        r_sh_ones  <= disp.score_ones;
        r_sh_tens  <= disp.score_tens;
        r_sh_lives <= disp.lives;
      end
      // A fresh drop restarts the blink sequence from its first half-period.
      if (w_lives_drop) begin
        r_blink_left <= 3'd6;
        r_blink_cnt  <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
        if (w_blink_wrap && (r_blink_left != 3'd0))
          r_blink_left <= r_blink_left - 1'b1;
      end
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
    end
  end

  assign disp.an  = r_an;
  assign disp.seg = r_seg;
  assign disp.dp  = 1'b1;

endmodule
